norm_nd: RTL and testbench

NORM_ND -- requirements
Module: norm_nd

---
 rtl/norm_nd.sv | 246 ++++++++++++++++++++++++
 tb/tb_norm_nd.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/norm_nd.sv
// Euclidean norm and normalisation of an N-element fixed-point vector.
// Iterative CORDIC vectoring for the magnitude, restoring division per element.
module norm_nd #(
  parameter int DIMENSIONS    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int FRAC_BITS     = 20,
  parameter int CORDIC_STAGES = 16,
  parameter int GUARD         = 6
) (
  input  logic                             clk,
  input  logic                             nreset,
  input  logic                             start,
  input  logic                             mode_mag_only,
  input  logic [DIMENSIONS*DATA_WIDTH-1:0] w_in,
  output logic                             busy,
  output logic                             done,
  output logic [DIMENSIONS*DATA_WIDTH-1:0] W_out,
  output logic [DATA_WIDTH-1:0]            norm_out,
  output logic                             zero_vec,
  output logic                             ovf
);

  localparam int N    = DIMENSIONS;
  localparam int DW   = DATA_WIDTH;
  localparam int XW   = DW + GUARD + 2;
  localparam int KF   = FRAC_BITS + GUARD;
  localparam int QW   = FRAC_BITS + 1;
  localparam int RW   = DW + 2;
  localparam int EW   = $clog2(N);
  localparam int SMAX = (CORDIC_STAGES > FRAC_BITS + 1) ? CORDIC_STAGES : FRAC_BITS + 1;
  localparam int SW   = $clog2(SMAX + 1);

  localparam int            KINV_I = $rtoi(0.6072529350 * (2.0 ** KF) + 0.5);
  localparam logic [KF:0]   KINV   = KINV_I[KF:0];
  localparam logic [DW+1:0] NMAX_N = {3'b000, {(DW-1){1'b1}}};
  localparam logic [DW:0]   ONE_A  = {{DW{1'b0}}, 1'b1};
  localparam logic [DW-1:0] ONE_D  = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_VEC  = 3'd1,
    S_COMP = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic [DW:0] abs_f(input logic [DW-1:0] v);
    if (v[DW-1]) abs_f = {1'b0, ~v} + ONE_A;
    else         abs_f = {1'b0, v};
  endfunction

  state_t                  state_r, state_s;
  logic [SW-1:0]           step_r;
  logic [EW-1:0]           elem_r;
  logic [N*DW-1:0]         w_r, res_r;
  logic                    mag_r, zero_r, ovf_r, neg_r;
  logic [XW-1:0]           acc_r;
  logic signed [XW-1:0]    x_r, y_r;
  logic [RW-1:0]           rem_r;
  logic [QW-2:0]           quo_r;

  logic [DW-1:0]           w_sel_s, norm_s, res_elem_s;
  logic [SW-1:0]           sh_s;
  logic signed [XW-1:0]    x_sh_s, y_sh_s;
  logic [XW+KF-1:0]        prod_s;
  logic [XW-1:0]           acc_raw_s, acc_new_s;
  logic                    clamp_s, norm_zero_s, ge_s, done_s, busy_s;
  logic [RW-1:0]           den_s, t_s, rem_nxt_s;
  logic [QW-1:0]           q_s;
  logic                    unused_s;

  // Shared datapath: CORDIC shifts, 1/K scaling with saturation, division step.
  always_comb begin
    w_sel_s   = w_r[elem_r*DW +: DW];
    sh_s      = step_r - SW'(1);
    x_sh_s    = x_r >>> sh_s;
    y_sh_s    = y_r >>> sh_s;
    prod_s    = {{KF{1'b0}}, x_r} * {{(XW-1){1'b0}}, KINV};
    acc_raw_s = prod_s[KF +: XW];
    clamp_s   = acc_raw_s[XW-1:GUARD] > NMAX_N;
    if (clamp_s) acc_new_s = {NMAX_N, {GUARD{1'b0}}};
    else         acc_new_s = acc_raw_s;
    norm_zero_s = (acc_new_s[XW-1:GUARD] == {(DW+2){1'b0}});
    norm_s    = acc_r[GUARD +: DW];
    den_s     = {2'b00, norm_s};
    if (step_r == SW'(1)) t_s = rem_r;
    else                  t_s = {rem_r[RW-2:0], 1'b0};
    ge_s      = (t_s >= den_s);
    if (ge_s) rem_nxt_s = t_s - den_s;
    else      rem_nxt_s = t_s;
    q_s       = {quo_r, ge_s};
    if (neg_r) res_elem_s = ~{{(DW-QW){1'b0}}, q_s} + ONE_D;
    else       res_elem_s = {{(DW-QW){1'b0}}, q_s};
    unused_s  = ^prod_s[KF-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!nreset) state_r <= S_IDLE;
    else         state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_VEC;
        else       state_s = S_IDLE;
      end
      S_VEC: begin
        if (step_r == SW'(CORDIC_STAGES)) state_s = S_COMP;
        else                              state_s = S_VEC;
      end
      S_COMP: begin
        if (elem_r != EW'(N-1))                    state_s = S_VEC;
        else if (mag_r || zero_r || norm_zero_s)   state_s = S_DONE;
        else                                       state_s = S_DIV;
      end
      S_DIV: begin
        if (step_r == SW'(FRAC_BITS+1) && elem_r == EW'(N-1)) state_s = S_DONE;
        else                                                  state_s = S_DIV;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output decode, registered below so busy and done change on the same edge.
  always_comb begin
    done_s = 1'b0;
    busy_s = 1'b1;
    case (state_r)
      S_IDLE:  busy_s = start;
      S_DONE: begin
        done_s = 1'b1;
        busy_s = 1'b0;
      end
      default: busy_s = 1'b1;
    endcase
  end

  // Result registers: only the done edge publishes new values.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      W_out    <= '0;
      norm_out <= '0;
      zero_vec <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      busy <= busy_s;
      done <= done_s;
      if (done_s) begin
        if (mag_r) W_out <= {{((N-1)*DW){1'b0}}, norm_s};
        else       W_out <= res_r;
        norm_out <= norm_s;
        zero_vec <= zero_r;
        ovf      <= ovf_r;
      end else begin
        W_out    <= W_out;
        norm_out <= norm_out;
        zero_vec <= zero_vec;
        ovf      <= ovf;
      end
    end
  end

  // Operand latch, CORDIC iterations, accumulator update and division steps.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      step_r <= '0;
      elem_r <= '0;
      w_r    <= '0;
      res_r  <= '0;
      mag_r  <= 1'b0;
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
      neg_r  <= 1'b0;
      acc_r  <= '0;
      x_r    <= '0;
      y_r    <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            w_r    <= w_in;
            mag_r  <= mode_mag_only;
            zero_r <= (w_in == {(N*DW){1'b0}});
            acc_r  <= {1'b0, abs_f(w_in[DW-1:0]), {GUARD{1'b0}}};
            ovf_r  <= 1'b0;
            res_r  <= '0;
            elem_r <= EW'(1);
            step_r <= '0;
          end
        end
        S_VEC: begin
          // acc is a magnitude, so x starts non-negative without a pre-rotation swap.
          if (step_r == '0) begin
            x_r <= acc_r;
            y_r <= {{2{w_sel_s[DW-1]}}, w_sel_s, {GUARD{1'b0}}};
          end else if (y_r[XW-1]) begin
            x_r <= x_r - y_sh_s;
            y_r <= y_r + x_sh_s;
          end else begin
            x_r <= x_r + y_sh_s;
            y_r <= y_r - x_sh_s;
          end
          if (step_r == SW'(CORDIC_STAGES)) step_r <= '0;
          else                              step_r <= step_r + SW'(1);
        end
        S_COMP: begin
          // Saturating each partial norm keeps x/y inside XW bits for any N.
          acc_r  <= acc_new_s;
          ovf_r  <= ovf_r | clamp_s;
          step_r <= '0;
          if (elem_r == EW'(N-1)) elem_r <= '0;
          else                    elem_r <= elem_r + EW'(1);
        end
        S_DIV: begin
          if (step_r == '0) begin
            rem_r  <= {1'b0, abs_f(w_sel_s)};
            neg_r  <= w_sel_s[DW-1];
            quo_r  <= '0;
            step_r <= step_r + SW'(1);
          end else if (step_r == SW'(FRAC_BITS+1)) begin
            res_r[elem_r*DW +: DW] <= res_elem_s;
            step_r <= '0;
            if (elem_r != EW'(N-1)) elem_r <= elem_r + EW'(1);
            else                    elem_r <= elem_r;
          end else begin
            rem_r  <= rem_nxt_s;
            quo_r  <= q_s[QW-2:0];
            step_r <= step_r + SW'(1);
          end
        end
        S_DONE:  step_r <= '0;
        default: step_r <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_nd.sv
// Directed, table-driven bench for norm_nd at default parameters.
module tb_norm_nd;
  localparam int     N   = 5;
  localparam int     DW  = 32;
  localparam int     ONE = 1048576;
  localparam longint TOL = 256;

  logic            clk = 1'b0, nreset = 1'b0, start = 1'b0, mode_mag_only = 1'b0;
  logic [N*DW-1:0] w_in = '0;
  logic [N*DW-1:0] W_out;
  logic [DW-1:0]   norm_out;
  logic            busy, done, zero_vec, ovf;
  int              n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  norm_nd dut (
    .clk(clk), .nreset(nreset), .start(start), .mode_mag_only(mode_mag_only),
    .w_in(w_in), .busy(busy), .done(done), .W_out(W_out),
    .norm_out(norm_out), .zero_vec(zero_vec), .ovf(ovf)
  );

  typedef struct {
    logic            mag;
    logic [N*DW-1:0] w;
    int              lat;
    longint          enorm;
    logic [N*DW-1:0] ew;
    logic            ez;
    logic            eo;
  } vec_t;

  function automatic logic [N*DW-1:0] pk(input int a, input int b, input int c, input int d, input int e);
    pk = {e, d, c, b, a};
  endfunction

  function automatic vec_t mk(input logic mag, input logic [N*DW-1:0] w, input int lat,
                              input longint enorm, input logic [N*DW-1:0] ew, input logic ez, input logic eo);
    mk.mag = mag; mk.w = w; mk.lat = lat; mk.enorm = enorm; mk.ew = ew; mk.ez = ez; mk.eo = eo;
  endfunction

  function automatic longint el(input logic [N*DW-1:0] v, input int i);
    logic signed [DW-1:0] s;
    s = v[i*DW +: DW];
    el = longint'(s);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp, input longint tol);
    longint d;
    n_vec++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  task automatic chk_zero_outs(input string nm);
    chk({nm, "_busy"}, longint'(busy), 0, 0);
    chk({nm, "_done"}, longint'(done), 0, 0);
    chk({nm, "_wout"}, longint'(W_out != '0), 0, 0);
    chk({nm, "_norm"}, longint'(norm_out), 0, 0);
    chk({nm, "_zero"}, longint'(zero_vec), 0, 0);
    chk({nm, "_ovf"},  longint'(ovf), 0, 0);
  endtask

  // Launches one operation and watches a fixed window after the accept edge.
  task automatic run(input logic mag, input logic [N*DW-1:0] w, input int dist_at, input int rst_at,
                     input longint hold_norm, output int lat, output int ndone,
                     output logic busy1, output logic busy_done);
    lat = -1; ndone = 0; busy1 = 1'b0; busy_done = 1'b1;
    @(negedge clk);
    mode_mag_only = mag; w_in = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode_mag_only = ~mag; w_in = ~w;
    for (int k = 1; k <= 220; k++) begin
      @(posedge clk); #1;
      if (k == 1) busy1 = busy;
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = k; busy_done = busy; end
      end
      if (k == 60 && hold_norm >= 0) chk("hold_norm", longint'(norm_out), hold_norm, TOL);
      if (k == dist_at) start = 1'b1;
      else              start = 1'b0;
      if (k == rst_at) nreset = 1'b0;
      if (k == rst_at + 1) begin
        chk_zero_outs("midrst");
        nreset = 1'b1;
      end
    end
  endtask

  task automatic check_result(input string nm, input vec_t v);
    longint tol;
    tol = (v.enorm == 0 || v.eo) ? 0 : TOL;
    chk({nm, "_norm"}, longint'(norm_out), v.enorm, tol);
    for (int i = 0; i < N; i++) begin
      tol = (el(v.ew, i) == 0) ? 0 : TOL;
      chk($sformatf("%s_w%0d", nm, i), el(W_out, i), el(v.ew, i), tol);
    end
    chk({nm, "_zero"}, longint'(zero_vec), longint'(v.ez), 0);
    chk({nm, "_ovf"},  longint'(ovf), longint'(v.eo), 0);
  endtask

  initial begin
    vec_t tbl[6];
    int   lat, nd;
    logic b1, bd;

    tbl[0] = mk(1'b0, pk(3*ONE, 4*ONE, 0, 0, 0), 183, 5*ONE, pk(629146, 838861, 0, 0, 0), 1'b0, 1'b0);
    tbl[1] = mk(1'b0, pk(5*ONE, 20*ONE, -4*ONE, 0, 3*ONE), 183, 22243656,
                pk(247151, 988607, -197722, 0, 148291), 1'b0, 1'b0);
    tbl[2] = mk(1'b0, pk(0, 0, 0, 0, 0), 73, 0, pk(0, 0, 0, 0, 0), 1'b1, 1'b0);
    tbl[3] = mk(1'b1, pk(3*ONE, 0, 4*ONE, 0, 0), 73, 5*ONE, pk(5*ONE, 0, 0, 0, 0), 1'b0, 1'b0);
    tbl[4] = mk(1'b0, pk(-3*ONE, 0, 0, 0, 4*ONE), 183, 5*ONE, pk(-629146, 0, 0, 0, 838861), 1'b0, 1'b0);
    tbl[5] = mk(1'b0, pk(2047*ONE, 2047*ONE, 2047*ONE, 2047*ONE, 2047*ONE), 183, 64'h7FFFFFFF,
                pk(1048064, 1048064, 1048064, 1048064, 1048064), 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk_zero_outs("reset");
    nreset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run(tbl[i].mag, tbl[i].w, -1, -1, -1, lat, nd, b1, bd);
      chk($sformatf("v%0d_latency", i), lat, tbl[i].lat, 0);
      chk($sformatf("v%0d_ndone", i), nd, 1, 0);
      chk($sformatf("v%0d_busy_start", i), longint'(b1), 1, 0);
      chk($sformatf("v%0d_busy_at_done", i), longint'(bd), 0, 0);
      check_result($sformatf("v%0d", i), tbl[i]);
    end

    // start re-pulsed mid-operation with different operands and mode
    run(1'b0, tbl[0].w, 40, -1, tbl[5].enorm, lat, nd, b1, bd);
    chk("restart_latency", lat, 183, 0);
    chk("restart_ndone", nd, 1, 0);
    check_result("restart", tbl[0]);

    // reset mid-operation discards the result
    run(1'b0, tbl[1].w, -1, 100, -1, lat, nd, b1, bd);
    chk("midrst_ndone", nd, 0, 0);
    chk_zero_outs("after_rst");

    run(1'b0, tbl[1].w, -1, -1, -1, lat, nd, b1, bd);
    chk("postrst_latency", lat, 183, 0);
    check_result("postrst", tbl[1]);

    // zero vector followed immediately by a mag-only start in the cycle after done
    @(negedge clk);
    mode_mag_only = 1'b0; w_in = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    chk("b2b_zero_latency", lat, 73, 0);
    chk("b2b_zero_flag", longint'(zero_vec), 1, 0);
    mode_mag_only = 1'b1; w_in = tbl[3].w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; w_in = '0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    chk("b2b_mag_latency", lat, 73, 0);
    check_result("b2b_mag", tbl[3]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
